const_conditional_seq: RTL and testbench
========================================

CONST_CONDITIONAL_SEQ -- requirements
Module: const_conditional_seq

Interface
REQ-001 Parameter: IN_W, 34, width of the flattened stimulus vector driven to the wrapped block.
REQ-002 Parameter: OUT_W, 24, width of the flattened response captured from the wrapped block.
REQ-003 Parameter: SETTLE_CYCLES, 2, number of clock edges from vector acceptance to response capture; legal range 1..255.
REQ-004 Parameter: CNT_W, 16, width of the completed-transaction counter.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 Port: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port: vec_valid, input, 1, stimulus vector offered.
REQ-009 Port: vec_data, input, IN_W, stimulus vector.
REQ-010 Port: vec_ready, output, 1, sequencer can accept a vector this cycle.
REQ-011 Port: dut_in, output, IN_W, registered vector driven to the wrapped block's in_flat.
REQ-012 Port: dut_out, input, OUT_W, wrapped block's out_flat.
REQ-013 Port: res_valid, output, 1, captured result available.
REQ-014 Port: res_data, output, IN_W+OUT_W, {applied vector, captured response}, vector in the MSBs.
REQ-015 Port: res_ready, input, 1, consumer accepts the result.
REQ-016 Port: flush, input, 1, synchronous abort of any in-flight transaction.
REQ-017 Port: busy, output, 1, high in any state other than IDLE.
REQ-018 Port: done_cnt, output, CNT_W, count of results handed off.

Function
REQ-019 FSM states SHALL be IDLE, WAIT and HOLD; vec_ready SHALL equal (state==IDLE), combinationally.
REQ-020 IDLE: on vec_valid&&vec_ready at edge k, the block SHALL register vec_data into dut_in, load the settle counter with SETTLE_CYCLES-1 and enter WAIT.
REQ-021 WAIT: the counter SHALL decrement each edge; at the edge where the counter is 0, the block SHALL register {dut_in, dut_out} into res_data and enter HOLD. Capture therefore occurs at edge k+SETTLE_CYCLES.
REQ-022 HOLD: res_valid SHALL be 1, and res_data SHALL remain stable regardless of dut_out changes until res_valid&&res_ready.
REQ-023 On the result handshake, the block SHALL return to IDLE at that edge, and vec_ready SHALL be 1 in the following cycle. A new vector SHALL NOT be accepted in the same cycle as the result handshake.
REQ-024 dut_in SHALL hold the last applied vector in every state and change only on acceptance.
REQ-025 done_cnt SHALL increment by 1 on each result handshake and saturate at all-ones (no wrap).
REQ-026 flush SHALL take priority over all other events: at the edge where flush=1, state SHALL go to IDLE, res_valid SHALL go to 0 and the counter SHALL clear, while dut_in and done_cnt are unchanged.
REQ-027 A flush concurrent with a result handshake SHALL NOT increment done_cnt.
REQ-028 A flush concurrent with vec_valid in IDLE SHALL NOT accept the vector.
REQ-029 vec_data SHALL be ignored when vec_ready=0, and no vector SHALL be lost or duplicated.

Reset
REQ-030 While rst_n=0, the block SHALL be in state IDLE with dut_in=0, res_valid=0, res_data=0, done_cnt=0, busy=0 and vec_ready=1, all asynchronously.
REQ-031 Reset asserted mid-transaction SHALL discard the transaction with no result emitted; the first vector after deassertion SHALL be processed normally.

Verification
REQ-032 Reset: assert rst_n=0 mid-WAIT -> outputs take REQ-030 values immediately, with no clock edge needed.
REQ-033 Single vector, SETTLE_CYCLES=2: accept vec_data=34'h2_0000_0001 at edge 0, dut_out=24'hABCDEF -> dut_in=34'h2_0000_0001 after edge 0; res_valid=1 after edge 2; res_data={34'h2_0000_0001,24'hABCDEF}.
REQ-034 Backpressure: hold res_ready=0 for 5 cycles in HOLD while changing dut_out to 24'h000000 -> res_data is unchanged, vec_ready=0 and busy=1 throughout.
REQ-035 Flush: pulse flush in WAIT -> IDLE at the next edge, no res_valid pulse, done_cnt unchanged, and dut_in retains the vector.
REQ-036 Back-to-back: result handshake at edge n with vec_valid held high -> next vector accepted at edge n+1, with result at edge n+1+SETTLE_CYCLES.
REQ-037 Saturation, CNT_W=2: complete 5 transactions -> done_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/const_conditional_seq.sv
// const_conditional_seq
// Drives one stimulus vector into a wrapped combinational/pipelined block,
// waits a fixed number of edges for it to settle, captures the applied vector
// together with the block's response, and holds that result until a consumer
// takes it. A synchronous flush aborts any transaction in flight.

module const_conditional_seq #(
    parameter int IN_W          = 34,
    parameter int OUT_W         = 24,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vec_valid,
    input  logic [IN_W-1:0]        vec_data,
    output logic                   vec_ready,
    output logic [IN_W-1:0]        dut_in,
    input  logic [OUT_W-1:0]       dut_out,
    output logic                   res_valid,
    output logic [IN_W+OUT_W-1:0]  res_data,
    input  logic                   res_ready,
    input  logic                   flush,
    output logic                   busy,
    output logic [CNT_W-1:0]       done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    // The settle counter is sized for the full legal SETTLE_CYCLES range.
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONE_MAX    = {CNT_W{1'b1}};

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [7:0]              settle_r;
    logic [7:0]              settle_nxt_s;
    logic                    accept_s;
    logic                    capture_s;
    logic                    handoff_s;
    logic [IN_W-1:0]         dut_in_r;
    logic [IN_W+OUT_W-1:0]   res_data_r;
    logic                    res_valid_r;
    logic                    busy_r;
    logic [CNT_W-1:0]        done_cnt_r;

    // Next-state and event decode; flush overrides every other event.
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        handoff_s    = 1'b0;
        if (flush) begin
            state_nxt_s  = IDLE;
            settle_nxt_s = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (vec_valid) begin
                        accept_s     = 1'b1;
                        settle_nxt_s = SETTLE_LOAD;
                        state_nxt_s  = WAIT;
                    end else begin
                        state_nxt_s  = IDLE;
                    end
                end
                WAIT: begin
                    if (settle_r == 8'd0) begin
                        capture_s   = 1'b1;
                        state_nxt_s = HOLD;
                    end else begin
                        settle_nxt_s = settle_r - 8'd1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        handoff_s   = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                default: begin
                    state_nxt_s  = IDLE;
                    settle_nxt_s = 8'd0;
                end
            endcase
        end
    end

    // State, settle counter and the status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            settle_r    <= 8'd0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            settle_r    <= settle_nxt_s;
            res_valid_r <= (state_nxt_s == HOLD);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    // Applied vector changes only when a new vector is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in_r <= '0;
        end else if (accept_s) begin
            dut_in_r <= vec_data;
        end else begin
            dut_in_r <= dut_in_r;
        end
    end

    // Result snapshot is taken once per transaction and then frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_r <= '0;
        end else if (capture_s) begin
            res_data_r <= {dut_in_r, dut_out};
        end else begin
            res_data_r <= res_data_r;
        end
    end

    // Count handed-off results, sticking at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_r <= '0;
        end else if (handoff_s && (done_cnt_r != DONE_MAX)) begin
            done_cnt_r <= done_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            done_cnt_r <= done_cnt_r;
        end
    end

    // vec_ready must reflect the current state within the same cycle.
    assign vec_ready = (state_r == IDLE);
    assign dut_in    = dut_in_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign busy      = busy_r;
    assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_const_conditional_seq.sv
// Directed testbench for const_conditional_seq. A default instance and a
// second instance with a 2-bit done counter share the same stimulus so the
// saturation behaviour is observed alongside the normal flow.

module tb_const_conditional_seq;

    localparam int IN_W  = 34;
    localparam int OUT_W = 24;

    logic                  clk;
    logic                  rst_n;
    logic                  vec_valid;
    logic [IN_W-1:0]       vec_data;
    logic [OUT_W-1:0]      dut_out;
    logic                  res_ready;
    logic                  flush;

    logic                  vec_ready;
    logic [IN_W-1:0]       dut_in;
    logic                  res_valid;
    logic [IN_W+OUT_W-1:0] res_data;
    logic                  busy;
    logic [15:0]           done_cnt;

    logic                  sat_vec_ready;
    logic [IN_W-1:0]       sat_dut_in;
    logic                  sat_res_valid;
    logic [IN_W+OUT_W-1:0] sat_res_data;
    logic                  sat_busy;
    logic [1:0]            sat_done_cnt;

    int n_checks;
    int n_errors;

    const_conditional_seq u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_valid (vec_valid),
        .vec_data  (vec_data),
        .vec_ready (vec_ready),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .flush     (flush),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    const_conditional_seq #(.CNT_W(2)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_valid (vec_valid),
        .vec_data  (vec_data),
        .vec_ready (sat_vec_ready),
        .dut_in    (sat_dut_in),
        .dut_out   (dut_out),
        .res_valid (sat_res_valid),
        .res_data  (sat_res_data),
        .res_ready (res_ready),
        .flush     (flush),
        .busy      (sat_busy),
        .done_cnt  (sat_done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: offer vec, wait (bounded) for result, hand it off.
    task automatic run_txn(input logic [IN_W-1:0] v, input logic [OUT_W-1:0] o);
        int waited;
        vec_valid = 1'b1;
        vec_data  = v;
        dut_out   = o;
        step();
        vec_valid = 1'b0;
        waited = 0;
        while (!res_valid && waited < 20) begin
            step();
            waited++;
        end
        check("txn_latency", 64'(waited), 64'(2));
        check("txn_res_data", 64'(res_data), 64'({v, o}));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        vec_valid = 1'b0;
        vec_data  = '0;
        dut_out   = '0;
        res_ready = 1'b0;
        flush     = 1'b0;
        #3;

        // Reset values
        check("rst_vec_ready", 64'(vec_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_dut_in", 64'(dut_in), 64'(0));
        check("rst_res_data", 64'(res_data), 64'(0));
        check("rst_done_cnt", 64'(done_cnt), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single vector, result two edges after acceptance
        vec_valid = 1'b1;
        vec_data  = 34'h2_0000_0001;
        dut_out   = 24'hABCDEF;
        step();
        vec_valid = 1'b0;
        check("single_dut_in", 64'(dut_in), 64'(34'h2_0000_0001));
        check("single_busy", 64'(busy), 64'(1));
        check("single_vec_ready", 64'(vec_ready), 64'(0));
        check("single_rv_e0", 64'(res_valid), 64'(0));
        step();
        check("single_rv_e1", 64'(res_valid), 64'(0));
        step();
        check("single_rv_e2", 64'(res_valid), 64'(1));
        check("single_res_data", 64'(res_data), 64'({34'h2_0000_0001, 24'hABCDEF}));

        // Backpressure: result frozen while the response changes
        dut_out = 24'h000000;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_res_data", 64'(res_data), 64'({34'h2_0000_0001, 24'hABCDEF}));
            check("bp_res_valid", 64'(res_valid), 64'(1));
            check("bp_vec_ready", 64'(vec_ready), 64'(0));
            check("bp_busy", 64'(busy), 64'(1));
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("hs_res_valid", 64'(res_valid), 64'(0));
        check("hs_vec_ready", 64'(vec_ready), 64'(1));
        check("hs_done_cnt", 64'(done_cnt), 64'(1));

        // Flush while waiting
        vec_valid = 1'b1;
        vec_data  = 34'h1_2345_6789;
        step();
        vec_valid = 1'b0;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_vec_ready", 64'(vec_ready), 64'(1));
        check("flush_dut_in", 64'(dut_in), 64'(34'h1_2345_6789));
        check("flush_done_cnt", 64'(done_cnt), 64'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_rv", 64'(res_valid), 64'(0));
        end

        // Flush with a vector offered in IDLE: vector must be dropped
        vec_valid = 1'b1;
        vec_data  = 34'h0_DEAD_BEEF;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        vec_valid = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'(0));
        check("flush_idle_dut_in", 64'(dut_in), 64'(34'h1_2345_6789));

        // Back-to-back with vec_valid held high and res_ready high
        vec_valid = 1'b1;
        vec_data  = 34'h3_0000_00AA;
        dut_out   = 24'h111111;
        res_ready = 1'b1;
        step();
        vec_data = 34'h0_0000_00BB;
        check("b2b_dut_in_a", 64'(dut_in), 64'(34'h3_0000_00AA));
        step();
        check("b2b_ignored", 64'(dut_in), 64'(34'h3_0000_00AA));
        step();
        check("b2b_rv_a", 64'(res_valid), 64'(1));
        check("b2b_res_a", 64'(res_data), 64'({34'h3_0000_00AA, 24'h111111}));
        step();
        check("b2b_hs_rv", 64'(res_valid), 64'(0));
        check("b2b_hs_ready", 64'(vec_ready), 64'(1));
        check("b2b_hs_dut_in", 64'(dut_in), 64'(34'h3_0000_00AA));
        check("b2b_hs_done", 64'(done_cnt), 64'(2));
        step();
        vec_valid = 1'b0;
        dut_out   = 24'h222222;
        check("b2b_dut_in_b", 64'(dut_in), 64'(34'h0_0000_00BB));
        check("b2b_busy_b", 64'(busy), 64'(1));
        step();
        check("b2b_rv_b_early", 64'(res_valid), 64'(0));
        step();
        check("b2b_rv_b", 64'(res_valid), 64'(1));
        check("b2b_res_b", 64'(res_data), 64'({34'h0_0000_00BB, 24'h222222}));
        step();
        res_ready = 1'b0;
        check("b2b_done_b", 64'(done_cnt), 64'(3));

        // Flush concurrent with the result handshake: no count
        vec_valid = 1'b1;
        vec_data  = 34'h2_5555_5555;
        step();
        vec_valid = 1'b0;
        step();
        step();
        check("fhs_rv", 64'(res_valid), 64'(1));
        res_ready = 1'b1;
        flush     = 1'b1;
        step();
        res_ready = 1'b0;
        flush     = 1'b0;
        check("fhs_rv_after", 64'(res_valid), 64'(0));
        check("fhs_busy", 64'(busy), 64'(0));
        check("fhs_done", 64'(done_cnt), 64'(3));

        // Asynchronous reset mid-WAIT
        vec_valid = 1'b1;
        vec_data  = 34'h1_0F0F_0F0F;
        step();
        vec_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dut_in", 64'(dut_in), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_vec_ready", 64'(vec_ready), 64'(1));
        check("arst_res_valid", 64'(res_valid), 64'(0));
        check("arst_res_data", 64'(res_data), 64'(0));
        check("arst_done", 64'(done_cnt), 64'(0));
        step();
        step();
        check("arst_no_rv", 64'(res_valid), 64'(0));
        rst_n = 1'b1;
        step();

        // Saturation on the 2-bit instance; default instance keeps counting
        run_txn(34'h0_0000_0001, 24'h000001);
        check("sat_1", 64'(sat_done_cnt), 64'(1));
        run_txn(34'h0_0000_0002, 24'h000002);
        check("sat_2", 64'(sat_done_cnt), 64'(2));
        run_txn(34'h0_0000_0003, 24'h000003);
        check("sat_3", 64'(sat_done_cnt), 64'(3));
        run_txn(34'h3_FFFF_FFFF, 24'hFFFFFF);
        check("sat_4", 64'(sat_done_cnt), 64'(3));
        run_txn(34'h2_AAAA_AAAA, 24'h555555);
        check("sat_5", 64'(sat_done_cnt), 64'(3));
        check("cnt_main_5", 64'(done_cnt), 64'(5));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
